// File: rtl/mul_pkg.sv
// Shared constants and helpers for the operand-product pipeline.
package mul_pkg;

  localparam int TRUNC       = 0;
  localparam int RND_HALF_UP = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mul_pair_stage.sv
// One tree level: multiplies adjacent operand pairs into double-width products and registers them.
// Total bus width is unchanged: N_IN/2 products of 2*W_IN bits each.
module mul_pair_stage #(
  parameter int N_IN = 4,
  parameter int W_IN = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 adv_i,
  input  logic                 vld_i,
  input  logic [N_IN*W_IN-1:0] dat_i,
  output logic                 vld_o,
  output logic [N_IN*W_IN-1:0] dat_o
);

  localparam int N_OUT = N_IN / 2;
  localparam int W_OUT = 2 * W_IN;

  logic [N_IN*W_IN-1:0] dat_d;
  logic [N_IN*W_IN-1:0] dat_q;
  logic                 vld_q;

  always_comb begin
    dat_d = '0;
    for (int k = 0; k < N_OUT; k++) begin
      dat_d[k*W_OUT +: W_OUT] = W_OUT'(dat_i[2*k*W_IN +: W_IN]) * W_OUT'(dat_i[(2*k+1)*W_IN +: W_IN]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
    end else if (adv_i) begin
      vld_q <= vld_i;
    end
  end

  // Data is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    if (adv_i) begin
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/mul_prod_pipe.sv
// Pipelined product of N_OPS unsigned operands: pairwise multiply tree, then scale/round/saturate.
// Latency log2(N_OPS)+1; the whole pipe stalls only when a valid result is not taken.
module mul_prod_pipe #(
  parameter int IN_W       = 10,
  parameter int N_OPS      = 4,
  parameter int OUT_W      = 40,
  parameter int FRAC_SHIFT = 0,
  parameter int ROUND      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_OPS*IN_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_sat
);

  import mul_pkg::*;

  localparam int LVLS    = clog2(N_OPS);
  localparam int PW      = N_OPS * IN_W;
  localparam int SW      = PW + 1;
  localparam bit RND_ON  = (ROUND == RND_HALF_UP) && (FRAC_SHIFT > 0);
  localparam int BIAS_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic [SW-1:0] RND_BIAS = RND_ON ? (SW'(1) << BIAS_SH) : '0;

  if (!(N_OPS == 2 || N_OPS == 4 || N_OPS == 8)) begin : g_bad_nops
    $error("mul_prod_pipe: N_OPS must be 2, 4 or 8");
  end
  if (FRAC_SHIFT >= PW) begin : g_bad_shift
    $error("mul_prod_pipe: FRAC_SHIFT must be below N_OPS*IN_W");
  end

  logic              adv;
  logic [PW-1:0]     lvl_dat [LVLS+1];
  logic              lvl_vld [LVLS+1];
  logic [SW-1:0]     s_d;
  logic [OUT_W-1:0]  res_d;
  logic              sat_d;
  logic              out_valid_q;
  logic [OUT_W-1:0]  out_data_q;
  logic              out_sat_q;

  assign adv        = out_ready | ~out_valid_q;
  assign in_ready   = adv;
  assign lvl_dat[0] = in_data;
  assign lvl_vld[0] = in_valid;

  for (genvar l = 0; l < LVLS; l++) begin : g_lvl
    mul_pair_stage #(
      .N_IN (N_OPS >> l),
      .W_IN (IN_W << l)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .adv_i (adv),
      .vld_i (lvl_vld[l]),
      .dat_i (lvl_dat[l]),
      .vld_o (lvl_vld[l+1]),
      .dat_o (lvl_dat[l+1])
    );
  end

  // One extra bit keeps the rounding add from wrapping.
  assign s_d = ({1'b0, lvl_dat[LVLS]} + RND_BIAS) >> FRAC_SHIFT;

  if (OUT_W >= SW) begin : g_nosat
    assign sat_d = 1'b0;
    assign res_d = OUT_W'(s_d);
  end else begin : g_sat
    assign sat_d = |s_d[SW-1:OUT_W];
    assign res_d = sat_d ? '1 : s_d[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (adv) begin
      out_valid_q <= lvl_vld[LVLS];
      out_data_q  <= res_d;
      out_sat_q   <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule

// File: doc/mul_prod_pipe.md
MUL_PROD_PIPE -- requirements
Module: mul_prod_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 10, unsigned operand width in bits.
REQ-002 SHALL have parameter N_OPS, default 4, operand count; legal values 2, 4, 8.
REQ-003 SHALL have parameter OUT_W, default 40, result width.
REQ-004 SHALL have parameter FRAC_SHIFT, default 0, right shift applied to the full product.
REQ-005 SHALL have parameter ROUND, default 0: 0 = truncate, 1 = round half up.
REQ-006 SHALL have port clk  in  1  single clock, rising edge.
REQ-007 SHALL have port rst  in  1  synchronous active-high reset.
REQ-008 SHALL have port in_valid  in  1  operand word valid.
REQ-009 SHALL have port in_ready  out  1  block accepts operand word.
REQ-010 SHALL have port in_data  in  N_OPS*IN_W  operand k at bits [k*IN_W +: IN_W].
REQ-011 SHALL have port out_valid  out  1  result valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts result.
REQ-013 SHALL have port out_data  out  OUT_W  scaled product.
REQ-014 SHALL have port out_sat  out  1  result was clipped; qualified by out_valid.
REQ-015 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-016 SHALL compute P = product of all N_OPS operands at full width N_OPS*IN_W, with no intermediate truncation.
REQ-017 SHALL form P with a balanced pairwise tree: log2(N_OPS) registered multiply levels, widths doubling per level.
REQ-018 SHALL apply scaling in a final registered stage: S = P >> FRAC_SHIFT if ROUND=0; S = (P + 2^(FRAC_SHIFT-1)) >> FRAC_SHIFT if ROUND=1 and FRAC_SHIFT>0, computed one bit wider so the addition cannot wrap.
REQ-019 SHALL saturate: if S >= 2^OUT_W, then out_data = all ones and out_sat = 1; otherwise out_data = S and out_sat = 0.
REQ-020 SHALL give latency L = log2(N_OPS)+1 cycles from an accepted input to out_valid, when no stall occurs.
REQ-021 SHALL carry one valid bit per stage alongside the data.
REQ-022 SHALL advance the whole pipe when adv = out_ready | ~out_valid; when adv=0, every stage holds.
REQ-023 SHALL drive in_ready = adv combinationally; an input is accepted when in_valid & in_ready.
REQ-024 SHALL let a stage register take bubbles while adv=1, so empty stages are filled and not held.
REQ-025 SHALL sustain throughput of 1 result per cycle when out_ready is held at 1.
REQ-026 SHALL hold out_data, out_sat and out_valid stable while out_valid=1 and out_ready=0.
REQ-027 SHALL neither drop nor duplicate a result when in_valid and out_ready toggle in the same cycle.
REQ-028 SHALL reject any N_OPS outside {2,4,8} at elaboration, and any FRAC_SHIFT >= N_OPS*IN_W.

Reset
REQ-029 SHALL clear every stage valid bit, out_valid, out_data and out_sat to 0 on rst=1.
REQ-030 SHALL discard in-flight data on reset mid-operation; no output SHALL appear for pre-reset inputs.
REQ-031 SHALL leave in_ready = 1 during and after reset, since out_valid=0.
REQ-032 SHALL not require resetting the data registers of internal stages, because valid bits gate them.

Structure
REQ-033 SHALL place the clog2 helper and the ROUND mode encodings (TRUNC=0, RND_HALF_UP=1) in the shared package mul_pkg.
REQ-034 SHALL implement one tree level as sub-module mul_pair_stage (params N_IN, W_IN), instantiated log2(N_OPS) times.

Verification
REQ-035 Bench SHALL apply defaults with operands 1023,1023,1023,1023 and out_ready=1 -> out_data=1095222947841, out_sat=0, exactly 3 cycles later.
REQ-036 Bench SHALL apply OUT_W=32 with the same operands -> out_data=0xFFFFFFFF, out_sat=1.
REQ-037 Bench SHALL apply FRAC_SHIFT=3 with operands 5,1,1,1 -> ROUND=0 gives 0, ROUND=1 gives 1; operands 3,1,1,1 with ROUND=1 give 0.
REQ-038 Bench SHALL stream 100 back-to-back inputs with random out_ready (50%) -> every result appears in order, none lost or duplicated, and out_data holds while stalled.
REQ-039 Bench SHALL assert rst for 1 cycle with 3 inputs in flight -> out_valid=0 next cycle and no stale result afterward.
REQ-040 Bench SHALL test N_OPS=2 and N_OPS=8 at IN_W=8 with all operands 255 -> results 65025 and 255^8 respectively, with latency 2 and 4.
